// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the VRAM port-A arbiter: state encoding,
// default geometry, and an index-width helper.
package vram_arb_pkg;

    localparam int VRAM_ADDR_W = 9;
    localparam int VRAM_DATA_W = 640;
    localparam int VRAM_NREQ   = 8;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_READ = 2'd1;
    localparam arb_state_t ST_XFER = 2'd2;
    localparam arb_state_t ST_ACK  = 2'd3;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vram_rmw_arbiter_rr_pick.sv
// Combinational round-robin picker: selects the first asserted request
// strictly after index `last`, wrapping around.
module rr_pick
    import vram_arb_pkg::*;
#(
    parameter int N_REQ = VRAM_NREQ,
    parameter int IDX_W = idx_width(VRAM_NREQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] start;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    assign start = (last == IDX_W'(N_REQ - 1)) ? '0 : last + 1'b1;

    // Rotate so bit 0 is the requester right after `last`, then take the lowest set bit.
    always_comb begin
        rot = N_REQ'({req, req} >> start);
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IDX_W'(k);
            end
        end
    end

    assign sum   = {1'b0, start} + {1'b0, off};
    assign idx   = (sum >= (IDX_W + 1)'(N_REQ)) ? IDX_W'(sum - (IDX_W + 1)'(N_REQ))
                                                : sum[IDX_W-1:0];
    assign valid = |req;

endmodule

// File: rtl/vram_rmw_arbiter.sv
// Round-robin owner of VRAM port A; each grant becomes a line read or a line write.
// Define VRAM_ARB_RMW_EN for masked read-modify-write; otherwise writes are full-line.
module vram_rmw_arbiter
    import vram_arb_pkg::*;
#(
    parameter int N_REQ  = VRAM_NREQ,
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int RD_LAT = 1
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    input  logic [N_REQ*DATA_W-1:0]  req_wmask,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic [ADDR_W-1:0]        vram_addr,
    output logic [DATA_W-1:0]        vram_din,
    output logic                     vram_wea,
    input  logic [DATA_W-1:0]        vram_dout
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int LAT_W = idx_width(RD_LAT) + 1;

    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];
`ifdef VRAM_ARB_RMW_EN
    logic [DATA_W-1:0] mask_arr  [N_REQ];
    logic [DATA_W-1:0] mask_reg;
`else
    logic              unused_wmask;
    assign unused_wmask = ^req_wmask;
`endif

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
`ifdef VRAM_ARB_RMW_EN
            assign mask_arr[gi]  = req_wmask[gi*DATA_W +: DATA_W];
`endif
        end
    endgenerate

    arb_state_t        state_reg;
    logic [IDX_W-1:0]  last_reg;
    logic [LAT_W-1:0]  lat_cnt_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [N_REQ-1:0]  gnt_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [DATA_W-1:0] line_wr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .last  (last_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            last_reg    <= IDX_W'(N_REQ - 1);
            lat_cnt_reg <= '0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            gnt_reg     <= '0;
            rdata_reg   <= '0;
`ifdef VRAM_ARB_RMW_EN
            mask_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        last_reg    <= pick_idx;
                        we_reg      <= req_we[pick_idx];
                        addr_reg    <= addr_arr[pick_idx];
                        wdata_reg   <= wdata_arr[pick_idx];
                        gnt_reg     <= N_REQ'(1) << pick_idx;
                        lat_cnt_reg <= '0;
`ifdef VRAM_ARB_RMW_EN
                        mask_reg    <= mask_arr[pick_idx];
                        state_reg   <= ST_READ;
`else
                        state_reg   <= req_we[pick_idx] ? ST_XFER : ST_READ;
`endif
                    end
                end
                ST_READ: begin
                    if (lat_cnt_reg == LAT_W'(RD_LAT - 1)) begin
                        state_reg <= ST_XFER;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (!we_reg) begin
                        rdata_reg <= vram_dout;
                    end
                    state_reg <= ST_ACK;
                end
                ST_ACK: begin
                    gnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Write strobe and data are decoded from state so an async reset kills them at once.
`ifdef VRAM_ARB_RMW_EN
    assign line_wr = (vram_dout & ~mask_reg) | (wdata_reg & mask_reg);
`else
    assign line_wr = wdata_reg;
`endif

    assign vram_wea  = (state_reg == ST_XFER) && we_reg;
    assign vram_din  = vram_wea ? line_wr : '0;
    assign vram_addr = addr_reg;
    assign gnt       = gnt_reg;
    assign ack       = (state_reg == ST_ACK) ? gnt_reg : '0;
    assign busy      = (state_reg != ST_IDLE);
    assign rdata     = rdata_reg;

endmodule
